// File: rtl/lifo_defs_pkg.sv
// Shared definitions for the parameterised LIFO stack.
//   - Default geometry (WIDTH/DEPTH).
//   - Reset value of the registered pop output.
//   - Encoding of the {push, pop} request pair.
package lifo_defs_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH = 16;

    // Every bit of the registered pop output resets to this value.
    localparam logic OUT_RST_BIT = 1'b0;

    // Decode of {push, pop}.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_SWAP = 2'b11
    } op_e;

endpackage

// File: rtl/lifo_mem.sv
// Storage array for the LIFO stack: DEPTH x WIDTH registers, not reset.
// Ports:
//   clk      clock
//   wr_en    write enable (synchronous)
//   wr_addr  write address
//   wr_data  write data
//   rd_addr  asynchronous read address
//   rd_data  asynchronous read data
module lifo_mem #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lifo_stack_param.sv
// Parameterised LIFO stack with occupancy count, threshold flags, sticky
// overflow/underflow, synchronous clear, combinational top-of-stack peek and
// simultaneous push+pop (replace-top).
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous active-low reset
//   push, pop     stack requests; both together replace the top entry
//   clear         synchronous flush, overrides push/pop
//   datain        push data
//   out           registered pop data (one cycle after pop)
//   out_valid     out carries newly popped data this cycle
//   top           current top entry, 0 when empty
//   count         number of stored entries
//   full, empty, almost_full, almost_empty   occupancy flags
//   overflow      sticky: push while full
//   underflow     sticky: pop while empty
module lifo_stack_param
    import lifo_defs_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned DEPTH     = DEFAULT_DEPTH,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = 2,
    parameter int unsigned CW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] datain,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [WIDTH-1:0] top,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CW-1:0]    sp_q, sp_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             vld_q, vld_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    top_idx;
    logic [WIDTH-1:0] rd_data;
    logic             is_full;
    logic             is_empty;
    op_e              op;

    assign op       = op_e'({push, pop});
    assign is_full  = (32'(sp_q) == DEPTH);
    assign is_empty = (sp_q == '0);
    // Guard the sp-1 index so an empty stack never reads out of range.
    assign top_idx  = is_empty ? '0 : AW'(sp_q - CW'(1));

    lifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (datain),
        .rd_addr (top_idx),
        .rd_data (rd_data)
    );

    always_comb begin
        sp_d    = sp_q;
        out_d   = out_q;
        vld_d   = 1'b0;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        wr_en   = 1'b0;
        wr_addr = AW'(sp_q);

        if (clear) begin
            sp_d  = '0;
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else begin
            unique case (op)
                OP_NONE: ;
                OP_PUSH: begin
                    if (is_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                        sp_d  = sp_q + CW'(1);
                    end
                end
                OP_POP: begin
                    if (is_empty) begin
                        unf_d = 1'b1;
                    end else begin
                        out_d = rd_data;
                        vld_d = 1'b1;
                        sp_d  = sp_q - CW'(1);
                    end
                end
                OP_SWAP: begin
                    vld_d = 1'b1;
                    if (is_empty) begin
                        // Bypass: the pushed word goes straight to out.
                        out_d = datain;
                    end else begin
                        out_d   = rd_data;
                        wr_en   = 1'b1;
                        wr_addr = top_idx;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_q  <= '0;
            out_q <= {WIDTH{OUT_RST_BIT}};
            vld_q <= 1'b0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            out_q <= out_d;
            vld_q <= vld_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign out          = out_q;
    assign out_valid    = vld_q;
    assign top          = is_empty ? '0 : rd_data;
    assign count        = sp_q;
    assign full         = is_full;
    assign empty        = is_empty;
    assign almost_full  = (32'(sp_q) >= AF_THRESH);
    assign almost_empty = (32'(sp_q) <= AE_THRESH);
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_lifo_stack_param.sv
// Bench for lifo_stack_param (WIDTH=8, DEPTH=4, AF_THRESH=3, AE_THRESH=1).
// A queue-based stack model runs alongside the DUT; a negedge process
// compares every output against it, and directed steps add literal checks.
module tb_lifo_stack_param;
    import lifo_defs_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned D  = 4;
    localparam int unsigned AF = 3;
    localparam int unsigned AE = 1;
    localparam int unsigned CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          push, pop, clear;
    logic [W-1:0]  datain;
    logic [W-1:0]  out, top;
    logic          out_valid, full, empty, almost_full, almost_empty;
    logic          overflow, underflow;
    logic [CW-1:0] count;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Model state
    logic [W-1:0] m_q [$];
    logic [W-1:0] m_out;
    logic         m_vld, m_ovf, m_unf;

    always #5 clk = ~clk;

    lifo_stack_param #(
        .WIDTH     (W),
        .DEPTH     (D),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .pop          (pop),
        .clear        (clear),
        .datain       (datain),
        .out          (out),
        .out_valid    (out_valid),
        .top          (top),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_out = '0;
        m_vld = 1'b0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_step(input logic p, input logic po, input logic c, input logic [W-1:0] d);
        m_vld = 1'b0;
        if (c) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (p && po) begin
            m_vld = 1'b1;
            if (m_q.size() == 0) begin
                m_out = d;
            end else begin
                m_out = m_q[$];
                m_q[$] = d;
            end
        end else if (p) begin
            if (m_q.size() == int'(D)) m_ovf = 1'b1;
            else m_q.push_back(d);
        end else if (po) begin
            if (m_q.size() == 0) begin
                m_unf = 1'b1;
            end else begin
                m_out = m_q.pop_back();
                m_vld = 1'b1;
            end
        end
    endtask

    // Drive one cycle, advance the model on the edge, release inputs #1 later.
    task automatic step(input logic p, input logic po, input logic c, input logic [W-1:0] d);
        push   = p;
        pop    = po;
        clear  = c;
        datain = d;
        @(posedge clk);
        model_step(p, po, c, d);
        #1;
        push  = 1'b0;
        pop   = 1'b0;
        clear = 1'b0;
    endtask

    // Continuous comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_count", 32'(count), 32'(m_q.size()));
            chk("cmp_out", 32'(out), 32'(m_out));
            chk("cmp_out_valid", 32'(out_valid), 32'(m_vld));
            chk("cmp_top", 32'(top), (m_q.size() == 0) ? 32'h0 : 32'(m_q[$]));
            chk("cmp_full", 32'(full), 32'(m_q.size() == int'(D)));
            chk("cmp_empty", 32'(empty), 32'(m_q.size() == 0));
            chk("cmp_almost_full", 32'(almost_full), 32'(m_q.size() >= int'(AF)));
            chk("cmp_almost_empty", 32'(almost_empty), 32'(m_q.size() <= int'(AE)));
            chk("cmp_overflow", 32'(overflow), 32'(m_ovf));
            chk("cmp_underflow", 32'(underflow), 32'(m_unf));
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] seq [4];
        seq[0] = 8'h0A; seq[1] = 8'h0B; seq[2] = 8'h0C; seq[3] = 8'h0D;

        rst = 1'b0; push = 1'b0; pop = 1'b0; clear = 1'b0; datain = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        chk_en = 1'b1;

        // Reset state
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_almost_empty", 32'(almost_empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_out", 32'(out), 32'd0);

        // Push/pop ordering
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, seq[i]);
            chk("fill_count", 32'(count), 32'(i + 1));
            chk("fill_almost_full", 32'(almost_full), 32'(i + 1 >= 3));
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_top", 32'(top), 32'h0D);
        for (int i = 3; i >= 0; i--) begin
            step(1'b0, 1'b1, 1'b0, 8'h00);
            chk("pop_out", 32'(out), 32'(seq[i]));
            chk("pop_out_valid", 32'(out_valid), 32'd1);
        end
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_count", 32'(count), 32'd0);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("idle_out_valid", 32'(out_valid), 32'd0);

        // Overflow
        step(1'b1, 1'b0, 1'b0, 8'h11);
        step(1'b1, 1'b0, 1'b0, 8'h22);
        step(1'b1, 1'b0, 1'b0, 8'h33);
        step(1'b1, 1'b0, 1'b0, 8'h44);
        chk("ovf_pre_flag", 32'(overflow), 32'd0);
        step(1'b1, 1'b0, 1'b0, 8'h55);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd4);
        chk("ovf_top", 32'(top), 32'h44);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        chk("ovf_pop_out", 32'(out), 32'h44);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Clear with simultaneous push (count=3, overflow=1)
        chk("clr_pre_count", 32'(count), 32'd3);
        step(1'b1, 1'b0, 1'b1, 8'h99);
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_empty", 32'(empty), 32'd1);
        chk("clr_overflow", 32'(overflow), 32'd0);
        chk("clr_out_hold", 32'(out), 32'h44);

        // Underflow
        step(1'b0, 1'b1, 1'b0, 8'h00);
        chk("unf_flag", 32'(underflow), 32'd1);
        chk("unf_out_valid", 32'(out_valid), 32'd0);
        chk("unf_out_hold", 32'(out), 32'h44);

        // Replace-top with entries present
        step(1'b1, 1'b0, 1'b0, 8'h10);
        step(1'b1, 1'b0, 1'b0, 8'h20);
        step(1'b1, 1'b0, 1'b0, 8'h22);
        step(1'b1, 1'b1, 1'b0, 8'h55);
        chk("swap_out", 32'(out), 32'h22);
        chk("swap_out_valid", 32'(out_valid), 32'd1);
        chk("swap_top", 32'(top), 32'h55);
        chk("swap_count", 32'(count), 32'd3);
        chk("swap_unf_sticky", 32'(underflow), 32'd1);

        // Replace-top while full raises no overflow
        step(1'b1, 1'b0, 1'b0, 8'h66);
        step(1'b1, 1'b1, 1'b0, 8'h77);
        chk("swap_full_out", 32'(out), 32'h66);
        chk("swap_full_top", 32'(top), 32'h77);
        chk("swap_full_ovf", 32'(overflow), 32'd0);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        chk("swap_full_pop", 32'(out), 32'h77);

        // Replace-top on empty stack (bypass)
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'h55);
        chk("bypass_out", 32'(out), 32'h55);
        chk("bypass_out_valid", 32'(out_valid), 32'd1);
        chk("bypass_count", 32'(count), 32'd0);
        chk("bypass_underflow", 32'(underflow), 32'd0);

        // Asynchronous reset mid-push
        step(1'b1, 1'b0, 1'b0, 8'h01);
        step(1'b1, 1'b0, 1'b0, 8'h02);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        chk("pre_arst_out", 32'(out), 32'h02);
        push   = 1'b1;
        datain = 8'hAB;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_out", 32'(out), 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        push = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        step(1'b1, 1'b0, 1'b0, 8'h5A);
        chk("post_arst_count", 32'(count), 32'd1);
        chk("post_arst_top", 32'(top), 32'h5A);

        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
